ws281x_chain_ctrl: RTL
======================

# ws281x_chain_ctrl

Parametrised WS281x frame controller: walks a linked list of pixel words in the pixel RAM, serialises each pixel's colour MSB-first into the bit encoder, and then holds the line for a programmable reset time. It sits between the RAM write side and the bit-code generator. It extends the fixed 24-bit/6-bit-address controller in four ways:
- configurable colour width (RGB or RGBW) and address width;
- a latched encoder-done handshake;
- queued frame requests;
- a frame-complete pulse.

## Interface
- COLOR_BITS, 24: bits per pixel, 24 (RGB) or 32 (RGBW); sent MSB first.
- ADDR_BITS, 6: RAM address width and next-pointer width.
- RST_BITS, 16: width of reset-time input.
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- bit_done_in  input  1  one-cycle pulse: encoder finished current bit and can accept another.
- wr_done_in  input  1  one-cycle pulse: frame written to RAM, request a send.
- rd_data_in  input  COLOR_BITS+ADDR_BITS  RAM word, valid 1 cycle after rd_en_out; [COLOR_BITS+:ADDR_BITS] is the next pointer, [COLOR_BITS-1:0] is the colour.
- rst_cnt_in  input  RST_BITS  reset length N; the line is held for 2N clocks after the last bit completes.
- bit_rdy_out  output  1  one-cycle pulse: bit_data_out is a new bit to encode.
- bit_data_out  output  1  current bit value; held between pulses.
- rd_en_out  output  1  RAM read strobe.
- rd_addr_out  output  ADDR_BITS  RAM read address.
- busy_out  output  1  high whenever the state is not IDLE.
- frame_done_out  output  1  one-cycle pulse when the reset phase ends.

## Operation
- States: IDLE, READ_RAM, SEND_BIT, SEND_RST. Reset values:
  - state is IDLE;
  - all outputs are 0, with rd_addr_out = 0;
  - pixel register, bit index, counters and all flags are 0.
- IDLE: on wr_done_in or wr_pend, go to READ_RAM and clear wr_pend. Set first_pend, meaning the encoder is idle.
- READ_RAM:
  - rd_en_out = (state==READ_RAM) & ~rd_done, which gives exactly one cycle.
  - rd_done is rd_en_out registered.
  - When rd_done is high: load the colour register, set rd_addr to the next pointer, go to SEND_BIT.
- SEND_BIT:
  - bit_next = first_pend | done_pend | bit_done_in.
  - On each bit_next: pulse bit_rdy_out and drive bit_data_out = colour[COLOR_BITS-1-bit_sel]. Then increment bit_sel and clear first_pend and done_pend.
  - When bit_next occurs with bit_sel == COLOR_BITS-1: go to SEND_RST if rd_addr == 0, otherwise go to READ_RAM.
  - bit_sel is cleared outside SEND_BIT.
- done_pend is set by bit_done_in in any state except when consumed in SEND_BIT. A done pulse arriving during READ_RAM is therefore never lost.
- SEND_RST:
  - rst_cnt (RST_BITS+1 wide) holds at 0 until done_pend is set, i.e. until the final bit has completed. It then increments every clock.
  - When rst_cnt == 2·rst_cnt_in: go to IDLE, pulse frame_done_out, clear done_pend.
  - N = 0 exits on the cycle after the final bit_done.
- wr_done_in while busy_out is high sets wr_pend. Multiple requests collapse into one queued frame.
- Every frame starts at address 0. A pointer of 0 terminates the chain, so a 1-pixel chain is the word at address 0 with pointer 0.
- An async reset mid-frame returns to IDLE immediately. No further bit_rdy_out is issued, and queued requests are lost.

## Timing
- wr_done_in sampled at edge E0:
  - rd_en_out is high in the cycle E0–E1;
  - colour is loaded at E2;
  - first bit_rdy_out is high in the cycle E3–E4.
- For a subsequent pixel, a bit_done_in sampled at edge E gives bit_rdy_out high in the cycle after E. The READ_RAM gap is 2 cycles and is hidden by done_pend.
- bit_data_out changes only in the same cycle that bit_rdy_out goes high.
- frame_done_out is high in the cycle IDLE is entered. A pending wr_pend leaves IDLE on the next edge.

## Configuration
- WS281X_AUTO_REFRESH_EN
  - Defined: once any frame has been requested since reset, the end of SEND_RST goes directly to READ_RAM, re-sending the chain continuously. frame_done_out still pulses every frame, and wr_done_in has no further effect.
  - Undefined: behaviour exactly as described above.

## Test plan
- Single pixel: addr0 = ptr 0, colour 0xA50F3C; rst_cnt_in = 4; encoder returns bit_done 10 cycles after each bit_rdy → 24 pulses carrying 1010_0101_0000_1111_0011_1100. After the 24th bit_done, exactly 8 cycles of SEND_RST, then frame_done_out.
- Chain 0→5→2→0: reads at addresses 0, 5, 2, each with rd_en_out high for 1 cycle; 72 bits in order. A bit_done_in landing during READ_RAM is still honoured, with no stall.
- COLOR_BITS = 32, colour 0x80000001: 32 pulses, first and last bits 1, all others 0.
- wr_done_in pulsed twice during a frame → exactly one extra frame after frame_done_out, then IDLE.
- Reset asserted at bit 10 of a pixel → all outputs 0 and IDLE. A later wr_done_in restarts from address 0.
- With WS281X_AUTO_REFRESH_EN: one wr_done_in gives at least 3 consecutive frames with equal frame_done_out spacing.

Source files
------------

// File: rtl/ws281x_chain_ctrl.sv
// WS281x frame controller: walks the pixel linked list from address 0, shifts each colour out MSB-first, then holds reset.
// Optional feature macro WS281X_AUTO_REFRESH_EN: after the first request the chain is re-sent continuously.
module ws281x_chain_ctrl #(
   parameter int COLOR_BITS = 24,
   parameter int ADDR_BITS  = 6,
   parameter int RST_BITS   = 16
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            bit_done_in,
   input  logic                            wr_done_in,
   input  logic [COLOR_BITS+ADDR_BITS-1:0] rd_data_in,
   input  logic [RST_BITS-1:0]             rst_cnt_in,
   output logic                            bit_rdy_out,
   output logic                            bit_data_out,
   output logic                            rd_en_out,
   output logic [ADDR_BITS-1:0]            rd_addr_out,
   output logic                            busy_out,
   output logic                            frame_done_out
);

   localparam int SEL_BITS = $clog2(COLOR_BITS);
   localparam logic [SEL_BITS-1:0] LAST_SEL = SEL_BITS'(COLOR_BITS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      READ_RAM = 2'd1,
      SEND_BIT = 2'd2,
      SEND_RST = 2'd3
   } state_t;

   state_t                  state_r, state_s;
   logic [COLOR_BITS-1:0]   color_r, color_s;
   logic [ADDR_BITS-1:0]    rd_addr_r, rd_addr_s;
   logic [SEL_BITS-1:0]     bit_sel_r, bit_sel_s;
   logic [RST_BITS:0]       rst_cnt_r, rst_cnt_s;
   logic [RST_BITS:0]       rst_goal_s;
   logic                    first_pend_r, first_pend_s;
   logic                    done_pend_r, done_pend_s;
   logic                    wr_pend_r, wr_pend_s;
   logic                    rd_en_r, rd_en_s;
   logic                    rd_done_r;
   logic                    bit_rdy_r, bit_rdy_s;
   logic                    bit_data_r, bit_data_s;
   logic                    busy_r, busy_s;
   logic                    frame_done_r, frame_done_s;
   logic                    bit_next_s;

   assign rst_goal_s = {rst_cnt_in, 1'b0};

   // Next-state and datapath decode
   always_comb begin
      state_s      = state_r;
      color_s      = color_r;
      rd_addr_s    = rd_addr_r;
      bit_sel_s    = '0;
      rst_cnt_s    = '0;
      first_pend_s = first_pend_r;
      done_pend_s  = done_pend_r | bit_done_in;
      wr_pend_s    = wr_pend_r | (wr_done_in & (state_r != IDLE));
      bit_rdy_s    = 1'b0;
      bit_data_s   = bit_data_r;
      frame_done_s = 1'b0;
      bit_next_s   = first_pend_r | done_pend_r | bit_done_in;
      case (state_r)
         IDLE: begin
            if (wr_done_in | wr_pend_r) begin
               state_s      = READ_RAM;
               wr_pend_s    = 1'b0;
               first_pend_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         READ_RAM: begin
            if (rd_done_r) begin
               color_s   = rd_data_in[COLOR_BITS-1:0];
               rd_addr_s = rd_data_in[COLOR_BITS +: ADDR_BITS];
               state_s   = SEND_BIT;
            end else begin
               state_s = READ_RAM;
            end
         end
         SEND_BIT: begin
            bit_sel_s = bit_sel_r;
            if (bit_next_s) begin
               bit_rdy_s    = 1'b1;
               bit_data_s   = color_r[LAST_SEL - bit_sel_r];
               bit_sel_s    = bit_sel_r + 1'b1;
               first_pend_s = 1'b0;
               done_pend_s  = 1'b0;
               // A zero next pointer terminates the chain
               if (bit_sel_r == LAST_SEL) begin
                  if (rd_addr_r == '0) begin
                     state_s = SEND_RST;
                  end else begin
                     state_s = READ_RAM;
                  end
               end else begin
                  state_s = SEND_BIT;
               end
            end else begin
               state_s = SEND_BIT;
            end
         end
         SEND_RST: begin
            // The reset timer starts only once the encoder reports the final bit complete
            if (done_pend_r) begin
               if (rst_cnt_r == rst_goal_s) begin
                  frame_done_s = 1'b1;
                  done_pend_s  = 1'b0;
`ifdef WS281X_AUTO_REFRESH_EN
                  state_s      = READ_RAM;
                  first_pend_s = 1'b1;
`else
                  state_s      = IDLE;
`endif
               end else begin
                  rst_cnt_s = rst_cnt_r + 1'b1;
               end
            end else begin
               rst_cnt_s = '0;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      rd_en_s = (state_s == READ_RAM) & (state_r != READ_RAM);
      busy_s  = (state_s != IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r      <= IDLE;
         color_r      <= '0;
         rd_addr_r    <= '0;
         bit_sel_r    <= '0;
         rst_cnt_r    <= '0;
         first_pend_r <= 1'b0;
         done_pend_r  <= 1'b0;
         wr_pend_r    <= 1'b0;
         rd_en_r      <= 1'b0;
         rd_done_r    <= 1'b0;
         bit_rdy_r    <= 1'b0;
         bit_data_r   <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         color_r      <= color_s;
         rd_addr_r    <= rd_addr_s;
         bit_sel_r    <= bit_sel_s;
         rst_cnt_r    <= rst_cnt_s;
         first_pend_r <= first_pend_s;
         done_pend_r  <= done_pend_s;
         wr_pend_r    <= wr_pend_s;
         rd_en_r      <= rd_en_s;
         rd_done_r    <= rd_en_r;
         bit_rdy_r    <= bit_rdy_s;
         bit_data_r   <= bit_data_s;
         busy_r       <= busy_s;
         frame_done_r <= frame_done_s;
      end
   end

   assign bit_rdy_out    = bit_rdy_r;
   assign bit_data_out   = bit_data_r;
   assign rd_en_out      = rd_en_r;
   assign rd_addr_out    = rd_addr_r;
   assign busy_out       = busy_r;
   assign frame_done_out = frame_done_r;

endmodule
